// File: rtl/dct_mem_sched.sv
// Streams image rows from an input SRAM through a 2-entry skid FIFO into a DCT core
// and writes the core's result rows to an output SRAM in order.
module dct_mem_sched #(
    parameter int NUM_ROWS = 32768,
    parameter int AW       = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          in_rd_en,
    output logic [AW-1:0] in_addr,
    input  logic [63:0]   in_rdata,
    output logic          dct_in_valid,
    output logic [63:0]   dct_in_data,
    input  logic          dct_in_ready,
    input  logic          dct_out_valid,
    input  logic [79:0]   dct_out_data,
    output logic          out_wr_en,
    output logic [AW-1:0] out_addr,
    output logic [79:0]   out_wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] ROWS = (AW+1)'(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [AW:0] rd_cnt, wr_cnt;
    logic        inflight;
    logic [63:0] fifo_mem [2];
    logic        fifo_rp, fifo_wp;
    logic [1:0]  fifo_cnt;
    logic [2:0]  slots_used;
    logic        accept, pop, push, wr_take, last_write;

    // A row popped this cycle frees its slot immediately, which is what lets
    // a 2-entry FIFO sustain one row per cycle against a 1-cycle SRAM.
    always_comb begin
        state_nxt    = state;
        accept       = (state == IDLE) && start && !done;
        dct_in_valid = (fifo_cnt != 2'd0);
        dct_in_data  = fifo_mem[fifo_rp];
        pop          = dct_in_valid && dct_in_ready;
        push         = inflight;
        slots_used   = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight};
        in_rd_en     = (state == RUN) && (rd_cnt < ROWS) && (slots_used < 3'd2);
        wr_take      = dct_out_valid && (state != IDLE) && (wr_cnt < ROWS);
        last_write   = (state == DRAIN) && (wr_cnt == ROWS);
        busy         = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (rd_cnt == ROWS) state_nxt = DRAIN;
            DRAIN:   if (last_write) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            in_addr   <= '0;
            inflight  <= 1'b0;
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
        end else begin
            state     <= state_nxt;
            done      <= last_write;
            inflight  <= in_rd_en;
            out_wr_en <= wr_take;
            if (accept) begin
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                in_addr <= '0;
            end else if (in_rd_en) begin
                rd_cnt  <= rd_cnt + (AW+1)'(1);
                in_addr <= in_addr + AW'(1);
            end
            if (wr_take) begin
                out_wdata <= dct_out_data;
                out_addr  <= wr_cnt[AW-1:0];
                wr_cnt    <= wr_cnt + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rp     <= 1'b0;
            fifo_wp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (accept) begin
            fifo_rp  <= 1'b0;
            fifo_wp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= in_rdata;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_mem_sched.sv
// Bench for dct_mem_sched: a 16-row instance driven through a table of passes
// plus a default-size instance for one full-image pass.
`timescale 1ns/1ps
module tb_dct_mem_sched;

    localparam int ROWS = 16;
    localparam int AW   = 4;

    typedef struct {
        int mode;
        int restart_at;
        bit start_at_done;
        int exp_reads;
        int exp_writes;
        int exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, reset_big, start, b_start;
    logic          in_rd_en, dct_in_valid, dct_in_ready, dct_out_valid;
    logic          out_wr_en, busy, done;
    logic [AW-1:0] in_addr, out_addr;
    logic [63:0]   in_rdata, dct_in_data;
    logic [79:0]   dct_out_data, out_wdata;
    logic          force_ov;
    logic [79:0]   force_od;

    logic          b_rd_en, b_in_valid, b_out_valid, b_wr_en, b_busy, b_done;
    logic [14:0]   b_in_addr, b_out_addr;
    logic [63:0]   b_rdata, b_in_data;
    logic [79:0]   b_out_data, b_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    int n_reads, n_deliv, n_writes, n_done, exp_rd_addr, occ_viol, first_rd, first_val;
    int b_reads = 0, b_writes = 0, b_done_n = 0, b_zero_wr = 0, b_bad = 0;
    int b_last_raddr = 0, b_last_waddr = 0;
    logic prev_busy = 1'b0;
    logic [83:0] wq[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    function automatic logic [63:0] pix(input int i);
        logic [15:0] s;
        s = i[15:0];
        return {s, ~s, s ^ 16'h5A5A, s + 16'h1234};
    endfunction

    function automatic logic [79:0] xform(input logic [63:0] d);
        return {d[15:0] ^ 16'hC3C3, d};
    endfunction

    dct_mem_sched #(.NUM_ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
        .dct_in_valid(dct_in_valid), .dct_in_data(dct_in_data), .dct_in_ready(dct_in_ready),
        .dct_out_valid(dct_out_valid), .dct_out_data(dct_out_data),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_wdata(out_wdata),
        .busy(busy), .done(done)
    );

    dct_mem_sched dut_big (
        .clk(clk), .reset(reset_big), .start(b_start),
        .in_rd_en(b_rd_en), .in_addr(b_in_addr), .in_rdata(b_rdata),
        .dct_in_valid(b_in_valid), .dct_in_data(b_in_data), .dct_in_ready(1'b1),
        .dct_out_valid(b_out_valid), .dct_out_data(b_out_data),
        .out_wr_en(b_wr_en), .out_addr(b_out_addr), .out_wdata(b_wdata),
        .busy(b_busy), .done(b_done)
    );

    // Input SRAM models and DCT cores: 8-stage delay line small, 1-stage big.
    logic [7:0]  pv;
    logic [79:0] pd [8];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_rdata <= '0;
            pv       <= '0;
        end else begin
            if (in_rd_en) in_rdata <= pix(int'(in_addr));
            pv    <= {pv[6:0], dct_in_valid & dct_in_ready};
            pd[0] <= xform(dct_in_data);
            for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
        end
    end

    assign dct_out_valid = pv[7] | force_ov;
    assign dct_out_data  = force_ov ? force_od : pd[7];

    always @(posedge clk or negedge reset_big) begin
        if (!reset_big) begin
            b_rdata     <= '0;
            b_out_valid <= 1'b0;
            b_out_data  <= '0;
        end else begin
            if (b_rd_en) b_rdata <= pix(int'(b_in_addr));
            b_out_valid <= b_in_valid;
            b_out_data  <= xform(b_in_data);
        end
    end

    task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_small();
        logic [83:0] e;
        if (in_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            check_output("rd_addr", 80'(in_addr), 80'(exp_rd_addr[AW-1:0]));
            exp_rd_addr++;
            n_reads++;
        end
        if (dct_in_valid && first_val < 0) first_val = cyc;
        if (dct_in_valid && dct_in_ready) begin
            check_output("dct_in_data", 80'(dct_in_data), 80'(pix(n_deliv)));
            wq.push_back({n_deliv[AW-1:0], xform(pix(n_deliv))});
            n_deliv++;
        end
        if (n_reads - n_deliv > 2) occ_viol++;
        if (out_wr_en) begin
            check_output("wr_expected", 80'(wq.size() != 0), 80'(1));
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check_output("wr_addr", 80'(out_addr), 80'(e[83:80]));
                check_output("wr_data", out_wdata, e[79:0]);
            end
            n_writes++;
        end
        if (done) begin
            n_done++;
            check_output("busy_at_done", 80'({prev_busy, busy}), 80'(2'b10));
        end
        prev_busy = busy;
    endtask

    task automatic monitor_big();
        if (b_rd_en) begin
            b_reads++;
            b_last_raddr = int'(b_in_addr);
        end
        if (b_wr_en) begin
            b_writes++;
            b_last_waddr = int'(b_out_addr);
            if (b_out_addr == 15'd0) b_zero_wr++;
            if (b_wdata !== xform(pix(int'(b_out_addr)))) b_bad++;
        end
        if (b_done) b_done_n++;
    endtask

    // One clock: ready is updated just after the edge, outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       dct_in_ready = 1'b1;
            1:       dct_in_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: dct_in_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        monitor_small();
        monitor_big();
    endtask

    task automatic begin_pass();
        wq.delete();
        n_reads = 0; n_deliv = 0; n_writes = 0; n_done = 0;
        exp_rd_addr = 0; occ_viol = 0; first_rd = -1; first_val = -1;
    endtask

    task automatic finish_pass(input vec_t v);
        for (int c = 1; c < 600 && n_done == 0; c++) begin
            start = (c == v.restart_at);
            tick();
        end
        start = v.start_at_done;
        check_output("done_seen", 80'(n_done != 0), 80'(1));
        for (int c = 0; c < 15; c++) begin
            tick();
            start = 1'b0;
        end
        check_output("reads", 80'(n_reads), 80'(v.exp_reads));
        check_output("writes", 80'(n_writes), 80'(v.exp_writes));
        check_output("done_count", 80'(n_done), 80'(v.exp_done));
        check_output("scoreboard_empty", 80'(wq.size()), 80'(0));
        check_output("occupancy_violations", 80'(occ_viol), 80'(0));
        check_output("rd_to_valid_latency", 80'(first_val - first_rd), 80'(2));
        check_output("busy_after_pass", 80'(busy), 80'(0));
    endtask

    task automatic apply_stimulus(input vec_t v);
        begin_pass();
        ready_mode = v.mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_after_start", 80'(busy), 80'(1));
        finish_pass(v);
    endtask

    initial begin
        vecs[0] = '{mode: 0, restart_at: -1, start_at_done: 1'b0, exp_reads: ROWS, exp_writes: ROWS, exp_done: 1};
        vecs[1] = '{mode: 1, restart_at: -1, start_at_done: 1'b0, exp_reads: ROWS, exp_writes: ROWS, exp_done: 1};
        vecs[2] = '{mode: 0, restart_at: 5,  start_at_done: 1'b0, exp_reads: ROWS, exp_writes: ROWS, exp_done: 1};
        vecs[3] = '{mode: 2, restart_at: -1, start_at_done: 1'b1, exp_reads: ROWS, exp_writes: ROWS, exp_done: 1};

        reset = 1'b0; reset_big = 1'b0; start = 1'b0; b_start = 1'b0;
        dct_in_ready = 1'b1; force_ov = 1'b0; force_od = '0;
        begin_pass();
        tick();
        tick();
        check_output("reset_rd_en", 80'(in_rd_en), 80'(0));
        check_output("reset_valid", 80'(dct_in_valid), 80'(0));
        check_output("reset_wr_en", 80'(out_wr_en), 80'(0));
        check_output("reset_busy_done", 80'({busy, done}), 80'(0));
        reset = 1'b1; reset_big = 1'b1;
        tick();

        // Core output while idle must not reach the output SRAM.
        force_od = 80'h1234_5678_9ABC_DEF0_1357;
        force_ov = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("idle_no_write", 80'(out_wr_en), 80'(0));
        end
        force_ov = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            $display("[TB] pass %0d ready_mode %0d", i, vecs[i].mode);
            apply_stimulus(vecs[i]);
        end

        // Abort after 7 reads, then restart from address 0.
        begin_pass();
        ready_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && n_reads < 7; c++) tick();
        reset = 1'b0;
        #1;
        check_output("abort_rd_en", 80'(in_rd_en), 80'(0));
        check_output("abort_in_addr", 80'(in_addr), 80'(0));
        check_output("abort_valid", 80'(dct_in_valid), 80'(0));
        check_output("abort_in_data", 80'(dct_in_data), 80'(0));
        check_output("abort_wr_en", 80'(out_wr_en), 80'(0));
        check_output("abort_out_addr", 80'(out_addr), 80'(0));
        check_output("abort_wdata", out_wdata, 80'(0));
        check_output("abort_busy_done", 80'({busy, done}), 80'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        begin_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("restart_first_read", 80'({in_rd_en, in_addr}), 80'({1'b1, 4'd0}));
        finish_pass(vecs[0]);

        // Full-size image on the default-parameter instance.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 34000 && b_done_n == 0; c++) tick();
        check_output("big_done_seen", 80'(b_done_n != 0), 80'(1));
        for (int c = 0; c < 5; c++) tick();
        check_output("big_reads", 80'(b_reads), 80'(32768));
        check_output("big_writes", 80'(b_writes), 80'(32768));
        check_output("big_last_raddr", 80'(b_last_raddr), 80'(32767));
        check_output("big_last_waddr", 80'(b_last_waddr), 80'(32767));
        check_output("big_zero_addr_writes", 80'(b_zero_wr), 80'(1));
        check_output("big_done_count", 80'(b_done_n), 80'(1));
        check_output("big_bad_data", 80'(b_bad), 80'(0));
        check_output("big_busy_after", 80'(b_busy), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
